// File: rtl/idu_decode_stage.sv
// ---------------------------------------------------------------------------
// idu_decode_stage
// RV32I decode stage with one output pipeline register between IFU and EXU.
// Decodes the incoming instruction into a one-hot format vector, an encoded
// command, the destination register and a sign-extended immediate. It
// registers these together with the PC and the register-file read data.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   IFU handshake (in_ready = !out_valid || out_ready)
//   in_inst, in_pc        instruction word and its PC
//   flush                 kill the held bundle and any same-cycle input
//   IDU_raddr1/2          combinational rs1/rs2 addresses to the regfile
//   rdata1/2              same-cycle regfile read data
//   out_valid / out_ready EXU handshake
//   out_pc, out_src1/2, out_rd, out_imm, out_type, out_cmd
//                         registered decoded bundle
//
// Optional feature macro: IDU_ILLEGAL_TRAP_EN
//   When defined, adds out_illegal, which flags unknown opcodes, non-32-bit
//   encodings and R-type instructions with an unsupported funct7.
// ---------------------------------------------------------------------------
module idu_decode_stage #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int CMD_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_inst,
    input  logic [PC_WIDTH-1:0]   in_pc,
    input  logic                  flush,
    output logic [ADDR_WIDTH-1:0] IDU_raddr1,
    output logic [ADDR_WIDTH-1:0] IDU_raddr2,
    input  logic [DATA_WIDTH-1:0] rdata1,
    input  logic [DATA_WIDTH-1:0] rdata2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [DATA_WIDTH-1:0] out_src1,
    output logic [DATA_WIDTH-1:0] out_src2,
    output logic [ADDR_WIDTH-1:0] out_rd,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [5:0]            out_type,
    output logic [CMD_WIDTH-1:0]  out_cmd
`ifdef IDU_ILLEGAL_TRAP_EN
    ,
    output logic                  out_illegal
`endif
);

    localparam logic [5:0] T_R = 6'b000001;
    localparam logic [5:0] T_I = 6'b000010;
    localparam logic [5:0] T_S = 6'b000100;
    localparam logic [5:0] T_B = 6'b001000;
    localparam logic [5:0] T_U = 6'b010000;
    localparam logic [5:0] T_J = 6'b100000;

    localparam logic [CMD_WIDTH-1:0] C_ALU_R  = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] C_ALU_I  = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] C_LOAD   = CMD_WIDTH'(3);
    localparam logic [CMD_WIDTH-1:0] C_JALR   = CMD_WIDTH'(4);
    localparam logic [CMD_WIDTH-1:0] C_STORE  = CMD_WIDTH'(5);
    localparam logic [CMD_WIDTH-1:0] C_BRANCH = CMD_WIDTH'(6);
    localparam logic [CMD_WIDTH-1:0] C_LUI    = CMD_WIDTH'(7);
    localparam logic [CMD_WIDTH-1:0] C_AUIPC  = CMD_WIDTH'(8);
    localparam logic [CMD_WIDTH-1:0] C_JAL    = CMD_WIDTH'(9);
    localparam logic [CMD_WIDTH-1:0] C_SYSTEM = CMD_WIDTH'(10);
    localparam logic [CMD_WIDTH-1:0] C_EBREAK = CMD_WIDTH'(11);

    logic [6:0]            opcode;
    logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [5:0]            dec_type;
    logic [CMD_WIDTH-1:0]  dec_cmd;
    logic [DATA_WIDTH-1:0] dec_imm;
    logic [ADDR_WIDTH-1:0] dec_rd;
    logic                  xfer_in;
`ifdef IDU_ILLEGAL_TRAP_EN
    logic                  dec_illegal;
`endif

    assign opcode     = in_inst[6:0];
    assign IDU_raddr1 = ADDR_WIDTH'(in_inst[19:15]);
    assign IDU_raddr2 = ADDR_WIDTH'(in_inst[24:20]);
    assign in_ready   = !out_valid || out_ready;
    assign xfer_in    = in_valid && in_ready;

    // Signed size casts sign-extend from inst[31] to any DATA_WIDTH >= 32.
    assign imm_i = DATA_WIDTH'($signed(in_inst[31:20]));
    assign imm_s = DATA_WIDTH'($signed({in_inst[31:25], in_inst[11:7]}));
    assign imm_b = DATA_WIDTH'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                        in_inst[11:8], 1'b0}));
    assign imm_u = DATA_WIDTH'($signed({in_inst[31:12], 12'b0}));
    assign imm_j = DATA_WIDTH'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                        in_inst[30:21], 1'b0}));

    always_comb begin
        dec_type = '0;
        dec_cmd  = '0;
        dec_imm  = '0;
        dec_rd   = ADDR_WIDTH'(in_inst[11:7]);
`ifdef IDU_ILLEGAL_TRAP_EN
        dec_illegal = 1'b0;
`endif
        case (opcode)
            7'b0110011: begin
                dec_type = T_R;
                dec_cmd  = C_ALU_R;
`ifdef IDU_ILLEGAL_TRAP_EN
                if (in_inst[31:25] != 7'b0000000 && in_inst[31:25] != 7'b0100000) begin
                    dec_cmd     = '0;
                    dec_illegal = 1'b1;
                end
`endif
            end
            7'b0010011: begin dec_type = T_I; dec_cmd = C_ALU_I; dec_imm = imm_i; end
            7'b0000011: begin dec_type = T_I; dec_cmd = C_LOAD;  dec_imm = imm_i; end
            7'b1100111: begin dec_type = T_I; dec_cmd = C_JALR;  dec_imm = imm_i; end
            7'b0100011: begin
                dec_type = T_S; dec_cmd = C_STORE;  dec_imm = imm_s; dec_rd = '0;
            end
            7'b1100011: begin
                dec_type = T_B; dec_cmd = C_BRANCH; dec_imm = imm_b; dec_rd = '0;
            end
            7'b0110111: begin dec_type = T_U; dec_cmd = C_LUI;   dec_imm = imm_u; end
            7'b0010111: begin dec_type = T_U; dec_cmd = C_AUIPC; dec_imm = imm_u; end
            7'b1101111: begin dec_type = T_J; dec_cmd = C_JAL;   dec_imm = imm_j; end
            7'b1110011: begin
                dec_type = T_I;
                dec_imm  = imm_i;
                dec_cmd  = (in_inst == 32'h0010_0073) ? C_EBREAK : C_SYSTEM;
            end
            default: begin
`ifdef IDU_ILLEGAL_TRAP_EN
                dec_illegal = 1'b1;
`endif
            end
        endcase
`ifdef IDU_ILLEGAL_TRAP_EN
        // Compressed encodings never match a listed opcode; kept explicit.
        if (in_inst[1:0] != 2'b11) dec_illegal = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_src1  <= '0;
            out_src2  <= '0;
            out_rd    <= '0;
            out_imm   <= '0;
            out_type  <= '0;
            out_cmd   <= '0;
`ifdef IDU_ILLEGAL_TRAP_EN
            out_illegal <= 1'b0;
`endif
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (xfer_in) begin
            out_valid <= 1'b1;
            out_pc    <= in_pc;
            out_src1  <= rdata1;
            out_src2  <= rdata2;
            out_rd    <= dec_rd;
            out_imm   <= dec_imm;
            out_type  <= dec_type;
            out_cmd   <= dec_cmd;
`ifdef IDU_ILLEGAL_TRAP_EN
            out_illegal <= dec_illegal;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
